// File: rtl/fir_mac_sequencer_if.sv
// Sample, result, coefficient-port and status signals of the time-multiplexed FIR.
// The source/sink side takes the master modport; the filter takes the slave modport.
interface fir_mac_sequencer_if #(
    parameter int TAPS = 4,
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int OW   = 8
);
    localparam int AW = $clog2(TAPS);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] x_in;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] y_out;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_wdata;
    logic          busy;

    modport master (
        output in_valid, x_in, out_ready, coef_we, coef_addr, coef_wdata,
        input  in_ready, out_valid, y_out, busy
    );

    modport slave (
        input  in_valid, x_in, out_ready, coef_we, coef_addr, coef_wdata,
        output in_ready, out_valid, y_out, busy
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// TAPS-tap unsigned FIR that uses one shared multiplier and computes one tap product per clock.
// Define FIR_SAT_EN to saturate y_out at 2^OW-1 instead of wrapping modulo 2^OW.
module fir_mac_sequencer #(
    parameter int TAPS = 4,
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int OW   = 8
) (
    input  logic               clk,
    input  logic               rst,
    fir_mac_sequencer_if.slave bus
);
    localparam int AW   = $clog2(TAPS);
    localparam int PW   = DW + CW;
    localparam int ACCW = PW + $clog2(TAPS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);
    localparam logic [AW:0]   TAPS_W = (AW + 1)'(TAPS);

    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   k_q, k_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [DW-1:0]   x_q [TAPS];
    logic [DW-1:0]   x_d [TAPS];
    logic [CW-1:0]   h_q [TAPS];
    logic [CW-1:0]   h_d [TAPS];
    logic [OW-1:0]   y_q, y_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic [PW-1:0]   prod_s;
    logic [ACCW-1:0] acc_sum_s;
    logic [OW-1:0]   y_sel_s;
    logic            addr_ok_s;

    // Operands are zero-extended so the product is computed at full DW+CW width.
    assign prod_s    = {{CW{1'b0}}, x_q[k_q]} * {{DW{1'b0}}, h_q[k_q]};
    assign acc_sum_s = acc_q + {{(ACCW - PW){1'b0}}, prod_s};
    assign addr_ok_s = ({1'b0, bus.coef_addr} < TAPS_W);

`ifdef FIR_SAT_EN
    assign y_sel_s = (acc_sum_s[ACCW-1:OW] != '0) ? {OW{1'b1}} : acc_sum_s[OW-1:0];
`else
    assign y_sel_s = acc_sum_s[OW-1:0];
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.y_out     = y_q;
    assign bus.busy      = busy_q;

    // Next-state logic: FSM, delay line, coefficient bank, accumulator, output register.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        acc_d       = acc_q;
        x_d         = x_q;
        h_d         = h_q;
        y_d         = y_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        // Coefficient writes land in the same edge as an accept, so the MAC sees the new value.
        if (bus.coef_we && (state_q == ST_IDLE) && addr_ok_s) begin
            h_d[bus.coef_addr] = bus.coef_wdata;
        end else begin
            h_d = h_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    x_d[0] = bus.x_in;
                    for (int i = 1; i < TAPS; i++) begin
                        x_d[i] = x_q[i-1];
                    end
                    acc_d      = '0;
                    k_d        = '0;
                    state_d    = ST_MAC;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                acc_d = acc_sum_s;
                if (k_q == K_LAST) begin
                    state_d     = ST_OUT;
                    y_d         = y_sel_s;
                    out_valid_d = 1'b1;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State registers; reset restores the default coefficient ramp h[i] = i+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                h_q[i] <= CW'(i + 1);
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            y_q         <= y_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            x_q         <= x_d;
            h_q         <= h_d;
        end
    end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed self-checking bench for fir_mac_sequencer (TAPS=4, DW=CW=OW=8, h reset to {1,2,3,4}).
// Expectations follow the FIR_SAT_EN setting of the build.
module tb_fir_mac_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    fir_mac_sequencer_if #(.TAPS(4), .DW(8), .CW(8), .OW(8)) bus ();

    fir_mac_sequencer #(.TAPS(4), .DW(8), .CW(8), .OW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Offers one sample and returns the edges from accept to out_valid (-1 on timeout) and y_out.
    task automatic send_sample(input logic [7:0] x, output int lat, output logic [7:0] y);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.x_in     = x;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus.out_valid !== 1'b1) lat = -1;
        y = bus.y_out;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.y_out !== 8'd0) begin
            n_bad++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b y=%0d, required 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.y_out);
        end
    endtask

    // Accepting edge counted as the first, out_valid is seen on the 5th edge: 4 edges after accept.
    task automatic test_impulse();
        logic [7:0] xs [4];
        logic [7:0] ye [4];
        int lat;
        logic [7:0] y;
        xs = '{8'd1, 8'd0, 8'd0, 8'd0};
        ye = '{8'd1, 8'd2, 8'd3, 8'd4};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_sample(xs[i], lat, y);
            n_cmp++;
            if (y !== ye[i]) begin
                n_bad++;
                $display("FAIL impulse_y[%0d]: got %0d required %0d", i, y, ye[i]);
            end
            n_cmp++;
            if (lat != 4) begin
                n_bad++;
                $display("FAIL impulse_latency[%0d]: got %0d required 4", i, lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_acc, ny, nlow;
        int acc_cyc [4];
        logic [7:0] ys [4];
        logic [7:0] ye [4];
        ye = '{8'd10, 8'd30, 8'd60, 8'd100};
        n_acc = 0; ny = 0; nlow = 0;
        for (int i = 0; i < 4; i++) begin
            acc_cyc[i] = -100;
            ys[i] = 8'd0;
        end
        do_reset();
        bus.out_ready = 1'b1;
        bus.x_in = 8'd10;
        for (int cyc = 0; cyc < 60 && ny < 4; cyc++) begin
            bus.in_valid = (n_acc < 4);
            if (bus.out_valid === 1'b1) begin
                if (ny < 4) ys[ny] = bus.y_out;
                ny++;
            end
            if (n_acc == 1 && bus.in_ready === 1'b0) nlow++;
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (ny != 4) begin
            n_bad++;
            $display("FAIL step_count: got %0d outputs required 4", ny);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ys[i] !== ye[i]) begin
                n_bad++;
                $display("FAIL step_y[%0d]: got %0d required %0d", i, ys[i], ye[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (acc_cyc[i+1] - acc_cyc[i] != 6) begin
                n_bad++;
                $display("FAIL throughput[%0d]: got %0d cycles required 6", i, acc_cyc[i+1] - acc_cyc[i]);
            end
        end
        n_cmp++;
        if (nlow != 5) begin
            n_bad++;
            $display("FAIL in_ready_low: got %0d cycles required 5", nlow);
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic [7:0] y;
        logic [7:0] exp2;
`ifdef FIR_SAT_EN
        exp2 = 8'd255;
`else
        exp2 = 8'd253;
`endif
        do_reset();
        send_sample(8'd255, lat, y);
        n_cmp++;
        if (y !== 8'd255) begin
            n_bad++;
            $display("FAIL overflow_y0: got %0d required 255", y);
        end
        send_sample(8'd255, lat, y);
        n_cmp++;
        if (y !== exp2) begin
            n_bad++;
            $display("FAIL overflow_y1: got %0d required %0d", y, exp2);
        end
    endtask

    task automatic test_stall();
        int lat, bad;
        logic [7:0] y;
        do_reset();
        bus.out_ready = 1'b0;
        send_sample(8'd7, lat, y);
        n_cmp++;
        if (y !== 8'd7 || lat != 4) begin
            n_bad++;
            $display("FAIL stall_first: got y=%0d lat=%0d required 7 and 4", y, lat);
        end
        bus.x_in = 8'd99;
        bus.in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.y_out !== 8'd7 || bus.in_ready !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL stall_hold: got %0d unstable cycles required 0", bad);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_release: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
        end
        // The stalled 99 must not have entered the delay line: 0*1 + 7*2.
        send_sample(8'd0, lat, y);
        n_cmp++;
        if (y !== 8'd14) begin
            n_bad++;
            $display("FAIL stall_next: got %0d required 14", y);
        end
    endtask

    task automatic test_coef();
        int lat, guard;
        logic [7:0] y;
        do_reset();
        bus.coef_we = 1'b1; bus.coef_addr = 2'd0; bus.coef_wdata = 8'd5;
        @(posedge clk); #1;
        bus.coef_we = 1'b0;
        send_sample(8'd2, lat, y);
        n_cmp++;
        if (y !== 8'd10) begin
            n_bad++;
            $display("FAIL coef_idle_write: got %0d required 10", y);
        end
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
        bus.x_in = 8'd1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.coef_we = 1'b1; bus.coef_addr = 2'd0; bus.coef_wdata = 8'd9;
        @(posedge clk); #1;
        bus.coef_we = 1'b0;
        guard = 0;
        while (bus.out_valid !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.y_out !== 8'd9) begin
            n_bad++;
            $display("FAIL coef_mac_sample: got %0d required 9", bus.y_out);
        end
        // x = {1,1,2,0}: h0 still 5 gives 5+2+6.
        send_sample(8'd1, lat, y);
        n_cmp++;
        if (y !== 8'd13) begin
            n_bad++;
            $display("FAIL coef_mac_ignored: got %0d required 13", y);
        end
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
        bus.coef_we = 1'b1; bus.coef_addr = 2'd1; bus.coef_wdata = 8'd7;
        bus.x_in = 8'd0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.coef_we = 1'b0; bus.in_valid = 1'b0;
        guard = 0;
        while (bus.out_valid !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
        // x = {0,1,1,2}, h = {5,7,3,4}: 0+7+3+8.
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.y_out !== 8'd18) begin
            n_bad++;
            $display("FAIL coef_same_cycle: got %0d required 18", bus.y_out);
        end
    endtask

    task automatic test_reset_mid();
        int lat, seen;
        logic [7:0] y;
        do_reset();
        bus.x_in = 8'd5; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL mac_status: busy=%b in_ready=%b required 1 0", bus.busy, bus.in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.y_out !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_mid_state: out_valid=%b in_ready=%b busy=%b y=%0d required 0 1 0 0",
                     bus.out_valid, bus.in_ready, bus.busy, bus.y_out);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL reset_mid_no_output: got %0d valid cycles required 0", seen);
        end
        send_sample(8'd3, lat, y);
        n_cmp++;
        if (y !== 8'd3) begin
            n_bad++;
            $display("FAIL reset_mid_next: got %0d required 3", y);
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.x_in       = 8'd0;
        bus.out_ready  = 1'b1;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = 2'd0;
        bus.coef_wdata = 8'd0;
        test_reset();
        test_impulse();
        test_back_to_back();
        test_overflow();
        test_stall();
        test_coef();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
